rom_prefetch: RTL and testbench
===============================

// Module: rom_prefetch
// PURPOSE
//  Instruction-fetch line buffer between the CPU ibus (classic WB slave side) and the boot ROM (WB B3 burst master side).
//  Holds one aligned line of LINE_WORDS 32-bit words; hits ack in 1 cycle; misses refill via wrapped critical-word-first burst.
//  Read-only path: writes are rejected with err, never forwarded to the ROM.
// PARAMETERS
//  ADDR_WIDTH  10  byte-address width of the ROM window (ROM word addr width + 2)
//  LINE_WORDS  4   words per line; legal 4/8/16 -> m_bte_o 2'b01/2'b10/2'b11
// PORTS
//  wb_clk      in   1           clock
//  wb_rst      in   1           reset, asynchronous, active-high
//  flush_i     in   1           invalidate line (1-cycle pulse)
//  s_adr_i     in   ADDR_WIDTH  CPU byte address, [1:0] ignored
//  s_cyc_i     in   1           CPU cycle
//  s_stb_i     in   1           CPU strobe
//  s_we_i      in   1           CPU write enable
//  s_dat_o     out  32          read data to CPU
//  s_ack_o     out  1           read ack
//  s_err_o     out  1           write error
//  m_adr_o     out  ADDR_WIDTH  ROM byte address (word-aligned)
//  m_cyc_o     out  1           ROM cycle
//  m_stb_o     out  1           ROM strobe
//  m_cti_o     out  3           3'b010 incr burst, 3'b111 last beat
//  m_bte_o     out  2           wrap size, from LINE_WORDS, static
//  m_dat_i     in   32          ROM data
//  m_ack_i     in   1           ROM ack
// BEHAVIOUR
//  Reset: all outputs 0 (m_bte_o keeps its static value), valid=0, state IDLE; async, takes effect mid-burst (ROM sees cyc drop).
//  req = s_cyc_i & s_stb_i & !s_ack_o & !s_err_o; tag = s_adr_i[ADDR_WIDTH-1:log2(LINE_WORDS)+2]; word = next log2(LINE_WORDS) bits.
//  States: IDLE, FILL.
//  IDLE, req & s_we_i: s_err_o=1 next cycle for exactly 1 cycle; no ROM access.
//  IDLE, req & !we & valid & tag==line_tag & !flush_i: s_dat_o=line[word], s_ack_o=1 next cycle, 1 cycle only.
//  IDLE, req & !we & (miss | flush_i): latch tag/word into miss_tag/beat_word, beats=0, -> FILL; next cycle m_cyc/stb=1, cti=010,
//   m_adr_o={miss_tag,beat_word,2'b00}; valid cleared on entry.
//  FILL: on each m_ack_i store m_dat_i at line[beat_word]; beat_word+=1 mod LINE_WORDS (wrap inside line); beats+=1.
//   m_adr_o follows beat_word; m_cti_o=3'b111 when beats==LINE_WORDS-1, else 3'b010.
//   Beat 0 (critical word): if req still active with same tag/word, s_dat_o=m_dat_i and s_ack_o=1 next cycle; else no ack.
//   Last ack: m_cyc/stb drop next cycle; line_tag=miss_tag; valid=!flush_seen; -> IDLE.
//   CPU requests during FILL other than critical word are not acked until back in IDLE (then served as hit/miss).
//  flush_i: IDLE -> valid=0 same edge; FILL -> sets flush_seen, line not validated at end; flush+hit same cycle -> miss.
//  m_ack_i outside FILL ignored. s_ack_o and s_err_o never high together.
//  Latency: hit 1 cycle; miss = 1 + ROM first-beat latency to critical word.
// STRUCTURE
//  Shared pkg wb_pkg: CTI_CLASSIC/CTI_INCR/CTI_EOB, BTE_LINEAR/WRAP4/WRAP8/WRAP16, function bte_for_words(n).
//  State enum local. Optional sub-module rom_prefetch_line: LINE_WORDS x 32 regfile, 1 write port, 1 async read port.
// TESTING
//  Cold read 0x008, ROM 1-cycle ack -> m_adr 0x008,0x00C,0x000,0x004, cti 010,010,010,111, bte 01; s_ack on beat 0 data.
//  Then read 0x004 -> hit, s_ack_o 1 cycle later with beat-3 data, m_cyc_o stays 0.
//  Read 0x010 after fill -> miss, new burst at 0x010; old line invalid afterwards (0x000 misses).
//  Write to 0x000 -> s_err_o pulse 1 cycle, s_ack_o 0, no m_cyc_o.
//  flush_i during FILL beat 2 -> burst completes 4 beats, next read same addr misses.
//  wb_rst asserted at beat 1 -> m_cyc_o/s_ack_o 0 immediately; first read after release is a miss.

Source files
------------

// File: rtl/wb_pkg.sv
// Wishbone B3 burst encodings shared by the boot-ROM fetch path.
package wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   // Wrap burst type matching a line of n words (linear for unsupported sizes).
   function automatic logic [1:0] bte_for_words(input int n);
      case (n)
         4:       return BTE_WRAP4;
         8:       return BTE_WRAP8;
         16:      return BTE_WRAP16;
         default: return BTE_LINEAR;
      endcase
   endfunction

endpackage

// File: rtl/rom_prefetch_if.sv
// Wishbone bus bundle; used for both the CPU ibus and the ROM burst side.
// dat carries read data only (slave -> master): this path never writes.
interface rom_prefetch_if #(parameter int ADDR_WIDTH = 10);
   logic [ADDR_WIDTH-1:0] adr;
   logic                  cyc;
   logic                  stb;
   logic                  we;
   logic [2:0]            cti;
   logic [1:0]            bte;
   logic [31:0]           dat;
   logic                  ack;
   logic                  err;

   modport master (output adr, cyc, stb, we, cti, bte, input dat, ack, err);
   modport slave  (input adr, cyc, stb, we, cti, bte, output dat, ack, err);
endinterface

// File: rtl/rom_prefetch_line.sv
// One cache line: LINE_WORDS x 32 storage, one write port, one async read port.
module rom_prefetch_line #(
   parameter  int LINE_WORDS = 4,
   localparam int IDX_W      = $clog2(LINE_WORDS)
) (
   input  logic             wb_clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [31:0]      wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [31:0]      rdata
);

   logic [31:0] mem [LINE_WORDS];

   // Burst beats land here; no reset, contents are qualified by the line valid bit.
   always_ff @(posedge wb_clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rom_prefetch.sv
// Instruction-fetch line buffer: single-cycle hits from one buffered line,
// misses refilled from the boot ROM with a wrapped critical-word-first burst.
module rom_prefetch
   import wb_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LINE_WORDS = 4
) (
   input  logic          wb_clk,
   input  logic          wb_rst,
   input  logic          flush_i,
   rom_prefetch_if.slave  s,
   rom_prefetch_if.master m
);

   localparam int IDX_W = $clog2(LINE_WORDS);
   localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

   typedef enum logic {IDLE, FILL} state_t;

   state_t             state, state_nxt;
   logic               valid, flush_seen, cyc, ack, err;
   logic [TAG_W-1:0]   line_tag, miss_tag;
   logic [IDX_W-1:0]   beat_word, beats;
   logic [31:0]        dat, line_rdata;

   logic               req, hit, crit, last_beat;
   logic               start_fill, fill_ack, rd_hit, wr_err;
   logic [TAG_W-1:0]   s_tag;
   logic [IDX_W-1:0]   s_word;
   logic               unused_ok;

   assign s_tag     = s.adr[ADDR_WIDTH-1 -: TAG_W];
   assign s_word    = s.adr[IDX_W+1 -: IDX_W];
   // A request already answered this cycle is not seen again.
   assign req       = s.cyc & s.stb & ~ack & ~err;
   // A flush in the same cycle forces the request down the miss path.
   assign hit       = valid & (s_tag == line_tag) & ~flush_i;
   assign last_beat = (beats == IDX_W'(LINE_WORDS - 1));
   // Critical word: the CPU is still waiting on exactly the word of beat 0.
   assign crit      = req & ~s.we & (s_tag == miss_tag) & (s_word == beat_word) & (beats == '0);

   // Next state and per-cycle decode of the CPU request / ROM ack.
   always_comb begin
      state_nxt  = state;
      start_fill = 1'b0;
      fill_ack   = 1'b0;
      rd_hit     = 1'b0;
      wr_err     = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (s.we)     wr_err = 1'b1;
               else if (hit) rd_hit = 1'b1;
               else begin
                  start_fill = 1'b1;
                  state_nxt  = FILL;
               end
            end
         end
         FILL: begin
            if (m.ack) begin
               fill_ack = 1'b1;
               if (last_beat) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; async reset abandons any burst in flight.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   // Line bookkeeping, burst address walk and CPU response registers.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         valid      <= 1'b0;
         flush_seen <= 1'b0;
         cyc        <= 1'b0;
         ack        <= 1'b0;
         err        <= 1'b0;
         dat        <= '0;
         line_tag   <= '0;
         miss_tag   <= '0;
         beat_word  <= '0;
         beats      <= '0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         if (wr_err) err <= 1'b1;
         if (rd_hit) begin
            ack <= 1'b1;
            dat <= line_rdata;
         end
         if (state == IDLE && flush_i) valid <= 1'b0;
         if (state == FILL && flush_i) flush_seen <= 1'b1;
         if (start_fill) begin
            miss_tag   <= s_tag;
            beat_word  <= s_word;
            beats      <= '0;
            valid      <= 1'b0;
            flush_seen <= 1'b0;
            cyc        <= 1'b1;
         end
         if (fill_ack) begin
            // IDX_W-bit counter wraps inside the line.
            beat_word <= beat_word + 1'b1;
            beats     <= beats + 1'b1;
            if (crit) begin
               ack <= 1'b1;
               dat <= m.dat;
            end
            if (last_beat) begin
               cyc      <= 1'b0;
               line_tag <= miss_tag;
               valid    <= ~(flush_seen | flush_i);
            end
         end
      end
   end

   rom_prefetch_line #(.LINE_WORDS(LINE_WORDS)) u_line (
      .wb_clk (wb_clk),
      .we     (fill_ack),
      .waddr  (beat_word),
      .wdata  (m.dat),
      .raddr  (s_word),
      .rdata  (line_rdata)
   );

   assign s.dat = dat;
   assign s.ack = ack;
   assign s.err = err;

   assign m.adr = {miss_tag, beat_word, 2'b00};
   assign m.cyc = cyc;
   assign m.stb = cyc;
   assign m.we  = 1'b0;
   assign m.cti = cyc ? (last_beat ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
   assign m.bte = bte_for_words(LINE_WORDS);

   // CPU burst hints, ROM err and byte-lane address bits carry no meaning here.
   assign unused_ok = &{1'b0, s.cti, s.bte, m.err, s.adr[1:0]};

endmodule

// File: tb/tb_rom_prefetch.sv
// Bench for rom_prefetch: directed vector table, reset/stray-ack sequences,
// then random traffic checked against a one-line cache model.
module tb_rom_prefetch;
   import wb_pkg::*;

   logic wb_clk = 1'b0;
   logic wb_rst = 1'b1;
   logic flush  = 1'b0;
   logic rdy    = 1'b1;
   logic stray  = 1'b0;
   logic [31:0] rom [256];

   rom_prefetch_if #(.ADDR_WIDTH(10)) s_bus ();
   rom_prefetch_if #(.ADDR_WIDTH(10)) m_bus ();

   assign s_bus.cti = CTI_CLASSIC;
   assign s_bus.bte = BTE_LINEAR;
   assign m_bus.err = 1'b0;
   assign m_bus.ack = (m_bus.cyc & m_bus.stb & rdy) | stray;
   assign m_bus.dat = rom[m_bus.adr[9:2]];

   rom_prefetch #(.ADDR_WIDTH(10), .LINE_WORDS(4)) dut (
      .wb_clk  (wb_clk),
      .wb_rst  (wb_rst),
      .flush_i (flush),
      .s       (s_bus.slave),
      .m       (m_bus.master)
   );

   always #5 wb_clk = ~wb_clk;

   int checks = 0;
   int errors = 0;

   bit          got_ack, got_err, saw_cyc, done;
   logic [31:0] got_dat;
   int          got_lat, first_beat;
   logic [9:0]  b_adr [$];
   logic [2:0]  b_cti [$];
   logic [1:0]  b_bte [$];

   bit          mvalid;
   logic [5:0]  mtag;

   typedef struct {
      logic [9:0] addr;
      bit         we;
      int         fb;     // -1 none, -2 flush with request, >=0 flush at that beat
      bit         e_ack;
      bit         e_err;
      int         e_beats;
      int         e_lat;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // One CPU transaction; runs until answered and the ROM bus is idle.
   task automatic xact(input logic [9:0] addr, input bit we, input int fb, input bit rnd);
      bit nrdy;
      got_ack = 0; got_err = 0; saw_cyc = 0; done = 0;
      got_dat = '0; got_lat = 0; first_beat = 0;
      b_adr.delete(); b_cti.delete(); b_bte.delete();
      @(negedge wb_clk);
      s_bus.adr = addr; s_bus.we = we; s_bus.cyc = 1'b1; s_bus.stb = 1'b1;
      flush = (fb == -2);
      rdy   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int it = 1; it <= 200; it++) begin
         @(negedge wb_clk);
         flush = 1'b0;
         if (m_bus.cyc) saw_cyc = 1;
         if (m_bus.ack) begin
            if (b_adr.size() == 0) first_beat = it;
            b_adr.push_back(m_bus.adr);
            b_cti.push_back(m_bus.cti);
            b_bte.push_back(m_bus.bte);
            if (fb >= 0 && b_adr.size() - 1 == fb) flush = 1'b1;
         end
         if ((s_bus.ack || s_bus.err) && !got_ack && !got_err) begin
            got_ack = s_bus.ack; got_err = s_bus.err; got_dat = s_bus.dat; got_lat = it;
            s_bus.cyc = 1'b0; s_bus.stb = 1'b0; s_bus.we = 1'b0;
         end
         if ((got_ack || got_err) && !m_bus.cyc) begin
            done = 1;
            break;
         end
         nrdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(posedge wb_clk);
         #1 rdy = nrdy;
      end
      if (!done) begin
         chk("timeout", 32'(done), 32'd1);
         s_bus.cyc = 1'b0; s_bus.stb = 1'b0; s_bus.we = 1'b0;
      end
      flush = 1'b0;
      @(negedge wb_clk);
      chk("resp_pulse", {30'd0, s_bus.ack, s_bus.err}, 32'd0);
   endtask

   task automatic check_common(input string nm, input logic [9:0] addr, input bit e_ack,
                               input bit e_err, input int e_beats, input int e_lat);
      logic [1:0] w;
      logic [9:0] ea;
      chk({nm, ".ack"}, 32'(got_ack), 32'(e_ack));
      chk({nm, ".err"}, 32'(got_err), 32'(e_err));
      chk({nm, ".beats"}, 32'(b_adr.size()), 32'(e_beats));
      chk({nm, ".lat"}, 32'(got_lat), 32'(e_lat));
      if (e_ack) chk({nm, ".dat"}, got_dat, rom[addr[9:2]]);
      if (e_beats == 0) chk({nm, ".no_cyc"}, 32'(saw_cyc), 32'd0);
      for (int k = 0; k < b_adr.size() && k < 4; k++) begin
         w  = addr[3:2] + 2'(k);
         ea = {addr[9:4], w, 2'b00};
         chk($sformatf("%s.adr%0d", nm, k), 32'(b_adr[k]), 32'(ea));
         chk($sformatf("%s.cti%0d", nm, k), 32'(b_cti[k]), (k == 3) ? 32'h7 : 32'h2);
         chk($sformatf("%s.bte%0d", nm, k), 32'(b_bte[k]), 32'h1);
      end
   endtask

   initial begin
      bit         we, miss;
      int         fb, r, e_lat;
      logic [9:0] addr;

      s_bus.adr = '0; s_bus.cyc = 1'b0; s_bus.stb = 1'b0; s_bus.we = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = $urandom;

      vecs[0]  = '{10'h008, 0, -1, 1, 0, 4, 2};  // cold miss, critical word first
      vecs[1]  = '{10'h004, 0, -1, 1, 0, 0, 1};  // hit on beat-3 data
      vecs[2]  = '{10'h010, 0, -1, 1, 0, 4, 2};  // new line
      vecs[3]  = '{10'h000, 0, -1, 1, 0, 4, 2};  // old line gone
      vecs[4]  = '{10'h000, 1, -1, 0, 1, 0, 1};  // write rejected
      vecs[5]  = '{10'h00C, 0, -1, 1, 0, 0, 1};  // line survives the write
      vecs[6]  = '{10'h014, 0,  2, 1, 0, 4, 2};  // flush during beat 2
      vecs[7]  = '{10'h014, 0, -1, 1, 0, 4, 2};  // so it misses again
      vecs[8]  = '{10'h018, 0, -1, 1, 0, 0, 1};  // now a hit
      vecs[9]  = '{10'h01C, 0, -2, 1, 0, 4, 2};  // flush with hit -> miss
      vecs[10] = '{10'h3FC, 0, -1, 1, 0, 4, 2};  // top word of window, wraps

      // Reset state.
      repeat (2) @(negedge wb_clk);
      chk("rst.s_ack", 32'(s_bus.ack), 32'd0);
      chk("rst.s_err", 32'(s_bus.err), 32'd0);
      chk("rst.s_dat", s_bus.dat, 32'd0);
      chk("rst.m_cyc", {30'd0, m_bus.cyc, m_bus.stb}, 32'd0);
      chk("rst.m_adr", 32'(m_bus.adr), 32'd0);
      chk("rst.m_cti", 32'(m_bus.cti), 32'd0);
      chk("rst.m_bte", 32'(m_bus.bte), 32'd1);
      wb_rst = 1'b0;

      foreach (vecs[i]) begin
         xact(vecs[i].addr, vecs[i].we, vecs[i].fb, 1'b0);
         check_common($sformatf("v%0d", i), vecs[i].addr, vecs[i].e_ack, vecs[i].e_err,
                      vecs[i].e_beats, vecs[i].e_lat);
      end

      // Stray ROM ack while idle must be ignored.
      @(negedge wb_clk); stray = 1'b1;
      @(negedge wb_clk); stray = 1'b0;
      chk("stray.m_cyc", 32'(m_bus.cyc), 32'd0);
      chk("stray.s_ack", 32'(s_bus.ack), 32'd0);
      xact(10'h3F4, 1'b0, -1, 1'b0);
      check_common("stray_hit", 10'h3F4, 1, 0, 0, 1);

      // Async reset in the middle of a burst.
      @(negedge wb_clk);
      s_bus.adr = 10'h040; s_bus.we = 1'b0; s_bus.cyc = 1'b1; s_bus.stb = 1'b1; rdy = 1'b1;
      @(negedge wb_clk);
      chk("mid.beat0", 32'(m_bus.ack), 32'd1);
      @(negedge wb_clk);
      chk("mid.crit_ack", 32'(s_bus.ack), 32'd1);
      wb_rst = 1'b1;
      #1;
      chk("mid.m_cyc", {30'd0, m_bus.cyc, m_bus.stb}, 32'd0);
      chk("mid.s_ack", 32'(s_bus.ack), 32'd0);
      s_bus.cyc = 1'b0; s_bus.stb = 1'b0;
      @(negedge wb_clk); wb_rst = 1'b0;
      xact(10'h040, 1'b0, -1, 1'b0);
      check_common("post_rst", 10'h040, 1, 0, 4, 2);
      mvalid = 1; mtag = 6'h04;

      // Random traffic with ROM wait states against the line model.
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 11) == 0) begin
            @(negedge wb_clk); flush = 1'b1;
            @(negedge wb_clk); flush = 1'b0;
            mvalid = 0;
         end
         addr = 10'($urandom_range(0, 3) * 16 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) addr[9:4] = 6'h04;
         we = ($urandom_range(0, 9) == 0);
         r  = $urandom_range(0, 9);
         fb = (r == 0) ? -2 : (r == 1) ? int'($urandom_range(0, 3)) : -1;
         if (fb == -2) mvalid = 0;
         miss = !we && !(mvalid && mtag == addr[9:4]);
         xact(addr, we, fb, 1'b1);
         e_lat = miss ? first_beat + 1 : 1;
         check_common($sformatf("r%0d", n), addr, !we, we, miss ? 4 : 0, e_lat);
         if (miss) begin
            mtag   = addr[9:4];
            mvalid = !(fb >= 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
